// File: rtl/iiitb_lifo_ctrl.sv
// Initiator-side controller for the 4-deep LIFO stack.
// Frames arrive on a valid/ready nibble stream. Each frame is pushed into the stack in
// groups of up to DEPTH nibbles. Each group is then popped out and presented reversed.
// The controller keeps its own occupancy count. A sticky err flag records any stack
// flag that disagrees with that count.
module iiitb_lifo_ctrl #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 4
) (
  input  logic         Clk,
  input  logic         Rst,
  // upstream nibble stream
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  input  logic         in_last,
  output logic         in_ready,
  // reversed downstream stream
  output logic [W-1:0] out_data,
  output logic         out_valid,
  output logic         out_last,
  input  logic         out_ready,
  // stack command / response
  output logic         st_EN,
  output logic         st_RW,
  output logic         st_Rst,
  output logic [W-1:0] st_dataIn,
  input  logic [W-1:0] st_dataOut,
  input  logic         st_EMPTY,
  input  logic         st_FULL,
  output logic         err
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(DEPTH);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [CntW-1:0] CntZero = '0;

  typedef enum logic [2:0] {
    StInit,
    StFill,
    StSettle,
    StPopReq,
    StPopWait,
    StPopCap,
    StEmit
  } state_e;

  state_e          state_q;
  logic [CntW-1:0] count_q;
  logic [W-1:0]    out_data_q;
  logic            out_valid_q;
  logic            out_last_q;
  logic            st_en_q;
  logic            st_rw_q;
  logic            st_rst_q;
  logic [W-1:0]    st_data_in_q;
  logic            err_q;

  logic            accept;
  logic [CntW-1:0] count_inc;
  logic [CntW-1:0] count_dec;
  logic            group_done;
  logic            flag_bad;

  // Handshake, count arithmetic and the stack-flag consistency check.
  always_comb begin
    in_ready   = (state_q == StFill) && (count_q < CntMax);
    accept     = in_valid && in_ready;
    count_inc  = count_q + CntOne;
    // Saturate at zero.
    count_dec  = (count_q != CntZero) ? (count_q - CntOne) : CntZero;
    group_done = in_last || (count_inc == CntMax);
    // The stack must hold exactly count_q items when a pop is about to be issued.
    flag_bad   = st_EMPTY || (st_FULL != (count_q == CntMax));
  end

  // Sequencer. All outputs to the stack and downstream are registered here.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q      <= StInit;
      count_q      <= CntZero;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      st_en_q      <= 1'b0;
      st_rw_q      <= 1'b0;
      st_rst_q     <= 1'b0;
      st_data_in_q <= '0;
      err_q        <= 1'b0;
    end else begin
      // Each stack command is a single-cycle strobe.
      st_en_q  <= 1'b0;
      st_rst_q <= 1'b0;
      unique case (state_q)
        StInit: begin
          // Clear the attached stack. It executes during the first FILL cycle.
          st_en_q  <= 1'b1;
          st_rst_q <= 1'b1;
          state_q  <= StFill;
        end
        StFill: begin
          if (accept) begin
            st_en_q      <= 1'b1;
            st_rw_q      <= 1'b0;
            st_data_in_q <= in_data;
            count_q      <= count_inc;
            if (group_done) begin
              state_q <= StSettle;
            end
          end
        end
        StSettle: begin
          // The final push executes at this cycle's closing edge.
          state_q <= StPopReq;
        end
        StPopReq: begin
          if (flag_bad) begin
            err_q <= 1'b1;
          end
          st_en_q <= 1'b1;
          st_rw_q <= 1'b1;
          state_q <= StPopWait;
        end
        StPopWait: begin
          state_q <= StPopCap;
        end
        StPopCap: begin
          out_data_q  <= st_dataOut;
          out_valid_q <= 1'b1;
          out_last_q  <= (count_q == CntOne);
          count_q     <= count_dec;
          state_q     <= StEmit;
        end
        StEmit: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            state_q     <= (count_q != CntZero) ? StPopReq : StFill;
          end
        end
        default: begin
          state_q <= StInit;
        end
      endcase
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign st_EN     = st_en_q;
  assign st_RW     = st_rw_q;
  assign st_Rst    = st_rst_q;
  assign st_dataIn = st_data_in_q;
  assign err       = err_q;

endmodule

// File: tb/tb_iiitb_lifo_ctrl.sv
// Bench for iiitb_lifo_ctrl: behavioural stack model, reversing reference model with a
// scoreboard queue, directed scenarios followed by randomized frames.
module tb_iiitb_lifo_ctrl;

  localparam int DEPTH = 4;
  localparam int W     = 4;

  logic         Clk = 1'b0;
  logic         Rst;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_last;
  logic         in_ready;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_last;
  logic         out_ready;
  logic         st_EN;
  logic         st_RW;
  logic         st_Rst;
  logic [W-1:0] st_dataIn;
  logic [W-1:0] st_dataOut;
  logic         st_EMPTY;
  logic         st_FULL;
  logic         err;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  always #5 Clk = ~Clk;
  always @(posedge Clk) cycle <= cycle + 1;

  iiitb_lifo_ctrl #(.DEPTH(DEPTH), .W(W)) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_ready (out_ready),
    .st_EN     (st_EN),
    .st_RW     (st_RW),
    .st_Rst    (st_Rst),
    .st_dataIn (st_dataIn),
    .st_dataOut(st_dataOut),
    .st_EMPTY  (st_EMPTY),
    .st_FULL   (st_FULL),
    .err       (err)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural stack ----------------
  logic [W-1:0] mem [DEPTH];
  int           sp = 0;
  logic [W-1:0] stk_out = '0;
  bit           force_empty = 0;

  always @(posedge Clk) begin
    if (st_EN) begin
      if (st_Rst) sp <= 0;
      else if (!st_RW) begin
        if (sp < DEPTH) begin
          mem[sp] <= st_dataIn;
          sp      <= sp + 1;
        end
      end else if (sp > 0) begin
        stk_out <= mem[sp-1];
        sp      <= sp - 1;
      end
    end
  end
  assign st_dataOut = stk_out;
  assign st_EMPTY   = (sp == 0) || force_empty;
  assign st_FULL    = (sp == DEPTH);

  // ---------------- reference model + scoreboard ----------------
  typedef struct packed {
    logic [W-1:0] data;
    logic         last;
  } beat_t;

  beat_t        exp_q[$];
  logic [W-1:0] grp[$];
  bit           lat_pending = 0;
  int           close_cycle = 0;
  logic         prev_valid = 0, prev_ready = 0, prev_last = 0;
  logic [W-1:0] prev_data = '0;

  always @(negedge Clk) begin
    if (Rst) begin
      exp_q.delete();
      grp.delete();
      lat_pending = 0;
      prev_valid  = 0;
    end else begin
      // A group closes on in_last or after DEPTH nibbles; it comes back reversed.
      if (in_valid && in_ready) begin
        grp.push_back(in_data);
        if (in_last || grp.size() == DEPTH) begin
          for (int i = grp.size() - 1; i >= 0; i--) begin
            beat_t b;
            b.data = grp[i];
            b.last = (i == 0);
            exp_q.push_back(b);
          end
          grp.delete();
          lat_pending = 1;
          close_cycle = cycle;
        end
      end
      if (out_valid && !prev_valid && lat_pending) begin
        chk("latency", cycle - close_cycle, 5);
        lat_pending = 0;
      end
      if (prev_valid && !prev_ready) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, prev_data);
        chk("hold_last", out_last, prev_last);
      end
      if (out_valid) begin
        chk("no_cmd_while_emit", st_EN, 0);
        chk("no_accept_while_emit", in_ready, 0);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", out_data, 'hEE);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          chk("out_data", out_data, e.data);
          chk("out_last", out_last, e.last);
        end
      end
      prev_valid = out_valid;
      prev_ready = out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end
  end

  // ---------------- stimulus helpers ----------------
  bit rand_ready_en = 0;
  always @(posedge Clk) begin
    if (rand_ready_en) begin
      #1 out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Present one nibble until accepted; returns just after the accepting edge.
  task automatic send_nibble(input logic [W-1:0] d, input bit last);
    int budget = 300;
    in_data  = d;
    in_last  = last;
    in_valid = 1'b1;
    forever begin
      @(negedge Clk);
      if (in_ready) break;
      budget--;
      if (budget == 0) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: in_ready stayed 0, expected 1 (t=%0t)", $time);
        break;
      end
    end
    @(posedge Clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_drain();
    int budget = 400;
    forever begin
      @(negedge Clk);
      if (exp_q.size() == 0 && !out_valid && grp.size() == 0) break;
      budget--;
      if (budget == 0) begin
        checks++;
        errors++;
        $display("FAIL drain_timeout: %0d beats pending, expected 0", exp_q.size());
        break;
      end
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic wait_out_valid();
    int budget = 100;
    forever begin
      @(negedge Clk);
      if (out_valid) break;
      budget--;
      if (budget == 0) begin
        checks++;
        errors++;
        $display("FAIL out_valid_timeout: out_valid stayed 0, expected 1");
        break;
      end
    end
  endtask

  task automatic do_reset(input int n);
    Rst = 1'b1;
    repeat (n) @(posedge Clk);
    #1;
    Rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    Rst       = 1'b1;
    in_data   = '0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;

    // Reset: every output zero while Rst is held.
    repeat (2) begin
      @(posedge Clk);
      @(negedge Clk);
      chk("reset_outputs",
          {in_ready, out_data, out_valid, out_last, st_EN, st_RW, st_Rst, st_dataIn, err}, 0);
    end
    @(posedge Clk);
    #1;
    Rst = 1'b0;
    // INIT cycle, then the one-cycle clear strobe with FILL open.
    @(negedge Clk);
    chk("init_en", st_EN, 0);
    chk("init_ready", in_ready, 0);
    @(negedge Clk);
    chk("clr_en", st_EN, 1);
    chk("clr_rst", st_Rst, 1);
    chk("fill_ready", in_ready, 1);
    @(negedge Clk);
    chk("clr_en_drop", st_EN, 0);
    chk("clr_rst_drop", st_Rst, 0);
    @(posedge Clk);
    #1;

    // 3-nibble frame.
    send_nibble(4'h1, 0);
    send_nibble(4'h2, 0);
    send_nibble(4'h3, 1);
    wait_drain();
    chk("err_clean", err, 0);

    // 6-nibble frame splits into groups of 4 and 2.
    for (int i = 1; i <= 6; i++) begin
      send_nibble(4'(i), i == 6);
      if (i == 4) begin
        @(negedge Clk);
        chk("ready_drop_full", in_ready, 0);
        @(posedge Clk);
        #1;
      end
    end
    wait_drain();

    // Back-pressure: 0xB held for 5 cycles.
    out_ready = 1'b0;
    send_nibble(4'hA, 0);
    send_nibble(4'hB, 1);
    wait_out_valid();
    repeat (5) begin
      chk("stall_data", out_data, 4'hB);
      chk("stall_valid", out_valid, 1);
      @(negedge Clk);
    end
    @(posedge Clk);
    #1;
    out_ready = 1'b1;
    wait_drain();

    // Reset in the middle of EMIT.
    out_ready = 1'b0;
    send_nibble(4'hC, 0);
    send_nibble(4'hD, 0);
    send_nibble(4'hE, 1);
    wait_out_valid();
    @(posedge Clk);
    #1;
    Rst = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    chk("midreset_valid", out_valid, 0);
    chk("midreset_data", out_data, 0);
    @(posedge Clk);
    #1;
    Rst       = 1'b0;
    out_ready = 1'b1;
    send_nibble(4'h7, 1);
    wait_drain();
    chk("stack_empty_after", sp, 0);

    // Forced EMPTY during the POP_REQ cycle.
    send_nibble(4'h5, 1);
    @(posedge Clk);
    #1;
    force_empty = 1;
    @(negedge Clk);
    chk("err_before", err, 0);
    @(posedge Clk);
    #1;
    force_empty = 0;
    @(negedge Clk);
    chk("err_set", err, 1);
    wait_drain();
    repeat (3) @(posedge Clk);
    #1;
    chk("err_sticky", err, 1);
    do_reset(1);
    @(negedge Clk);
    chk("err_cleared", err, 0);
    @(posedge Clk);
    #1;

    // Randomized frames with random gaps and back-pressure.
    rand_ready_en = 1;
    for (int f = 0; f < 40; f++) begin
      int len;
      len = $urandom_range(1, 9);
      for (int k = 0; k < len; k++) begin
        repeat ($urandom_range(0, 2)) @(posedge Clk);
        #1;
        send_nibble(4'($urandom), k == len - 1);
      end
    end
    wait_drain();
    rand_ready_en = 0;
    chk("scoreboard_empty", exp_q.size(), 0);
    chk("err_random", err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/iiitb_lifo_ctrl.md
Name: iiitb_lifo_ctrl

Overview:
Initiator-side controller for the team's 4-deep, 4-bit LIFO stack (EN/RW/dataIn command port; dataOut/EMPTY/FULL response). It accepts a nibble stream on a valid/ready input and pushes each frame into the stack. It then pops the frame out and presents it reversed on a valid/ready output. It owns stack reset and sequencing, and tracks occupancy itself.

Parameters:
DEPTH, 4, stack depth; must equal the attached stack's depth.
W, 4, data width in bits.

Ports:
Clk  input  1  clock; all logic on rising edge
Rst  input  1  synchronous, active-high reset
in_data  input  W  upstream nibble
in_valid  input  1  upstream data valid
in_last  input  1  marks final nibble of a frame
in_ready  output  1  controller accepts in_data this cycle
out_data  output  W  reversed-stream nibble (registered)
out_valid  output  1  out_data valid
out_last  output  1  final nibble of a drained group
out_ready  input  1  downstream accepts
st_EN  output  1  stack enable (registered)
st_RW  output  1  stack op: 0 push, 1 pop (registered)
st_Rst  output  1  stack reset (registered)
st_dataIn  output  W  push data (registered)
st_dataOut  input  W  stack pop data
st_EMPTY  input  1  stack empty flag
st_FULL  input  1  stack full flag; unused except via err
err  output  1  sticky: stack flag disagreed with internal count

Behaviour:
- Reset (Rst=1): state=INIT, count=0, out_valid=0, out_last=0, out_data=0, in_ready=0, err=0, st_EN=0, st_RW=0, st_Rst=0, st_dataIn=0. Rst overrides everything, including mid-frame or mid-drain.
- States: INIT, FILL, SETTLE, POP_REQ, POP_WAIT, POP_CAP, EMIT.
- INIT: one cycle. On exit edge, register st_EN=1 and st_Rst=1, and go to FILL. The stack clears during the first FILL cycle. st_Rst is cleared on the next edge.
- st_EN is high for exactly one cycle per command. Default each edge: st_EN=0, st_Rst=0.
- FILL:
  - in_ready = (count<DEPTH), combinational from state/count.
  - Handshake (in_valid&in_ready): register st_EN=1, st_RW=0, st_dataIn=in_data; count+1.
  - If in_last, or count+1==DEPTH, go to SETTLE. Otherwise stay in FILL.
  - in_last on a non-accepted cycle is ignored.
- SETTLE: one idle cycle so the final push executes; in_ready=0. Next state is POP_REQ.
- POP_REQ:
  - Check st_EMPTY; it must be 0. If st_EMPTY=1, set err (sticky until Rst).
  - Register st_EN=1, st_RW=1. Go to POP_WAIT.
- POP_WAIT: the stack executes the pop at this cycle's closing edge. Next state is POP_CAP.
- POP_CAP:
  - Register out_data=st_dataOut, out_valid=1, out_last=(count==1); count-1. Go to EMIT.
  - st_dataOut is sampled only in this state.
- EMIT:
  - Hold out_data/out_valid/out_last stable while out_ready=0.
  - On out_ready, clear out_valid/out_last. Go to POP_REQ if count!=0, else FILL.
- Latency: POP_REQ to out_valid is 3 cycles. Last input accept to first out_valid is 5 cycles. No push/pop overlap; input is stalled during the drain.
- Frame longer than DEPTH: after DEPTH accepts without in_last, drain the group with out_last on its final nibble. Resume FILL for the remainder. Each group is reversed independently.
- count is 3 bits, range 0..DEPTH. Never increment past DEPTH; never decrement below 0.
- st_RW is don't-care when st_EN=0 but holds its last value. st_dataIn holds its last value.

Test Plan:
- Reset with Rst=1 for 2 cycles -> all outputs 0. After release: INIT pulses st_EN=1/st_Rst=1 for one cycle, then in_ready=1.
- Push 0x1,0x2,0x3 (last on 0x3), out_ready=1 -> out_data 0x3,0x2,0x1; out_last only on 0x1; first out_valid 5 cycles after accepting 0x3; err=0.
- Push 0x1..0x6 (last on 0x6) -> in_ready drops after 0x4. Output 0x4,0x3,0x2,0x1 (last on 0x1), then 0x6,0x5 (last on 0x5).
- Frame 0xA,0xB (last) with out_ready=0 for 5 cycles -> out_data=0xB held with out_valid=1, no further stack command; after release 0xB then 0xA.
- Assert Rst during EMIT of a 3-nibble frame -> outputs reset next edge; INIT re-clears the stack; the following frame 0x7 reverses to 0x7 alone.
- Force st_EMPTY=1 during a POP_REQ cycle -> err=1 from the next cycle, held until Rst.
